// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, immediate formats and per-opcode operand decode
package riscv_pkg;

   localparam int REG_AW = 5;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_e;

   typedef struct packed {
      logic      use_rs1;
      logic      use_rs2;
      logic      regwrite;
      logic      illegal;
      imm_type_e imm_type;
   } dec_t;

   function automatic dec_t decode_op(input logic [6:0] op);
      dec_t d;
      d.use_rs1  = 1'b0;
      d.use_rs2  = 1'b0;
      d.regwrite = 1'b0;
      d.illegal  = 1'b0;
      d.imm_type = IMM_NONE;
      case (op)
         OPC_LUI, OPC_AUIPC: begin
            d.regwrite = 1'b1;
            d.imm_type = IMM_U;
         end
         OPC_JAL: begin
            d.regwrite = 1'b1;
            d.imm_type = IMM_J;
         end
         OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
            d.use_rs1  = 1'b1;
            d.regwrite = 1'b1;
            d.imm_type = IMM_I;
         end
         OPC_OP: begin
            d.use_rs1  = 1'b1;
            d.use_rs2  = 1'b1;
            d.regwrite = 1'b1;
         end
         OPC_STORE: begin
            d.use_rs1  = 1'b1;
            d.use_rs2  = 1'b1;
            d.imm_type = IMM_S;
         end
         OPC_BRANCH: begin
            d.use_rs1  = 1'b1;
            d.use_rs2  = 1'b1;
            d.imm_type = IMM_B;
         end
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - sign-extended RV32I immediate from instruction bits and format
module imm_gen
   import riscv_pkg::*;
(
   input  logic [31:7] i_instr,
   input  imm_type_e   i_imm_type,
   output logic [31:0] o_imm
);

   always_comb begin
      o_imm = '0;
      case (i_imm_type)
         IMM_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U:   o_imm = {i_instr[31:12], 12'b0};
         IMM_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
         default: o_imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - RV32I decode/issue stage with busy scoreboard
// Holds one instruction, reads operands, issues to execute over valid/ready.
module decode_issue
   import riscv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int PC_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [XLEN-1:0]   if_instr,
   input  logic [PC_W-1:0]   if_pc,
   input  logic              flush,
   output logic [REG_AW-1:0] Rs1,
   output logic [REG_AW-1:0] Rs2,
   input  logic [XLEN-1:0]   Read_data1,
   input  logic [XLEN-1:0]   Read_data2,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [PC_W-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_val,
   output logic [XLEN-1:0]   ex_rs2_val,
   output logic [31:0]       ex_imm,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_regwrite,
   output logic              ex_illegal,
   output logic [6:0]        ex_opcode,
   output logic [2:0]        ex_funct3,
   output logic              ex_funct7b5,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_rd
);

   logic              r_id_valid;
   logic [XLEN-1:0]   r_id_instr;
   logic [PC_W-1:0]   r_id_pc;
   logic [NREG-1:0]   r_busy;
   logic              r_ex_valid;
   logic [PC_W-1:0]   r_ex_pc;
   logic [XLEN-1:0]   r_ex_rs1_val;
   logic [XLEN-1:0]   r_ex_rs2_val;
   logic [31:0]       r_ex_imm;
   logic [REG_AW-1:0] r_ex_rd;
   logic              r_ex_regwrite;
   logic              r_ex_illegal;
   logic [6:0]        r_ex_opcode;
   logic [2:0]        r_ex_funct3;
   logic              r_ex_funct7b5;

   dec_t              w_dec;
   logic [REG_AW-1:0] w_rs1;
   logic [REG_AW-1:0] w_rs2;
   logic [REG_AW-1:0] w_rd;
   logic              w_hazard;
   logic              w_issue;
   logic              w_accept;
   logic [31:0]       w_imm;
   logic [NREG-1:0]   w_busy_nxt;

   imm_gen u_imm_gen (
      .i_instr    (r_id_instr[31:7]),
      .i_imm_type (w_dec.imm_type),
      .o_imm      (w_imm)
   );

   always_comb begin
      w_dec    = decode_op(r_id_instr[6:0]);
      w_rs1    = r_id_valid ? r_id_instr[19:15] : '0;
      w_rs2    = r_id_valid ? r_id_instr[24:20] : '0;
      w_rd     = r_id_instr[11:7];
      // busy[0] is never set, so x0 sources and rd=0 cannot stall
      w_hazard = (w_dec.use_rs1 & r_busy[w_rs1]) |
                 (w_dec.use_rs2 & r_busy[w_rs2]) |
                 (w_dec.regwrite & r_busy[w_rd]);
      w_issue  = r_id_valid & ~w_hazard & (~r_ex_valid | ex_ready) & ~flush;
      if_ready = flush | ~r_id_valid | w_issue;
      w_accept = if_valid & if_ready & ~flush;
   end

   // Clears first so that a same-cycle set on the same register wins
   always_comb begin
      w_busy_nxt = r_busy;
      if (wb_valid)
         w_busy_nxt[wb_rd] = 1'b0;
      if (flush && r_ex_valid && r_ex_regwrite)
         w_busy_nxt[r_ex_rd] = 1'b0;
      if (w_issue && w_dec.regwrite)
         w_busy_nxt[w_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_id_valid    <= 1'b0;
         r_id_instr    <= '0;
         r_id_pc       <= '0;
         r_busy        <= '0;
         r_ex_valid    <= 1'b0;
         r_ex_pc       <= '0;
         r_ex_rs1_val  <= '0;
         r_ex_rs2_val  <= '0;
         r_ex_imm      <= '0;
         r_ex_rd       <= '0;
         r_ex_regwrite <= 1'b0;
         r_ex_illegal  <= 1'b0;
         r_ex_opcode   <= '0;
         r_ex_funct3   <= '0;
         r_ex_funct7b5 <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;

         if (flush)
            r_id_valid <= 1'b0;
         else if (w_accept) begin
            r_id_valid <= 1'b1;
            r_id_instr <= if_instr;
            r_id_pc    <= if_pc;
         end else if (w_issue)
            r_id_valid <= 1'b0;

         if (flush)
            r_ex_valid <= 1'b0;
         else if (w_issue) begin
            r_ex_valid    <= 1'b1;
            r_ex_pc       <= r_id_pc;
            r_ex_rs1_val  <= Read_data1;
            r_ex_rs2_val  <= Read_data2;
            r_ex_imm      <= w_imm;
            r_ex_rd       <= w_rd;
            r_ex_regwrite <= w_dec.regwrite;
            r_ex_illegal  <= w_dec.illegal;
            r_ex_opcode   <= r_id_instr[6:0];
            r_ex_funct3   <= r_id_instr[14:12];
            r_ex_funct7b5 <= r_id_instr[30];
         end else if (ex_ready)
            r_ex_valid <= 1'b0;
      end
   end

   assign Rs1         = w_rs1;
   assign Rs2         = w_rs2;
   assign ex_valid    = r_ex_valid;
   assign ex_pc       = r_ex_pc;
   assign ex_rs1_val  = r_ex_rs1_val;
   assign ex_rs2_val  = r_ex_rs2_val;
   assign ex_imm      = r_ex_imm;
   assign ex_rd       = r_ex_rd;
   assign ex_regwrite = r_ex_regwrite;
   assign ex_illegal  = r_ex_illegal;
   assign ex_opcode   = r_ex_opcode;
   assign ex_funct3   = r_ex_funct3;
   assign ex_funct7b5 = r_ex_funct7b5;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - directed and random checks of decode_issue against a reference model
module tb_decode_issue;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_valid, if_ready, flush, ex_valid, ex_ready, wb_valid;
   logic [31:0] if_instr, if_pc;
   logic [4:0]  Rs1, Rs2, ex_rd, wb_rd;
   logic [31:0] Read_data1, Read_data2;
   logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
   logic        ex_regwrite, ex_illegal, ex_funct7b5;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic [31:0] wb_data;

   logic [31:0] regs [32];
   assign Read_data1 = regs[Rs1];
   assign Read_data2 = regs[Rs2];

   always #5 clk = ~clk;

   decode_issue dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .Rs1(Rs1), .Rs2(Rs2),
      .Read_data1(Read_data1), .Read_data2(Read_data2), .ex_valid(ex_valid),
      .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
      .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_illegal(ex_illegal), .ex_opcode(ex_opcode),
      .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .wb_valid(wb_valid),
      .wb_rd(wb_rd)
   );

   typedef struct packed {
      logic        u1, u2, wr, ill;
      logic [31:0] imm;
   } ref_t;

   typedef struct {
      logic [31:0] pc, r1, r2, imm, instr;
      logic        wr, ill;
   } ex_t;

   int          total = 0;
   int          bad   = 0;
   bit          m_idv, m_exv, m_acc;
   logic [31:0] m_idi, m_idpc;
   ex_t         e;
   int          pend[$];
   int          retire[$];
   logic [31:0] seen[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic ref_t ref_dec(input logic [31:0] i);
      ref_t r;
      logic signed [31:0] s;
      s = i;
      r = '0;
      case (i[6:0])
         7'h37, 7'h17: begin r.wr = 1; r.imm = i & 32'hFFFF_F000; end
         7'h6F: begin
            r.wr  = 1;
            r.imm = 32'((s >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
         end
         7'h67, 7'h03, 7'h13: begin r.u1 = 1; r.wr = 1; r.imm = 32'(s >>> 20); end
         7'h33: begin r.u1 = 1; r.u2 = 1; r.wr = 1; end
         7'h23: begin
            r.u1 = 1; r.u2 = 1;
            r.imm = 32'((s >>> 25) << 5) | 32'(i[11:7]);
         end
         7'h63: begin
            r.u1 = 1; r.u2 = 1;
            r.imm = 32'((s >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
         end
         default: r.ill = 1;
      endcase
      return r;
   endfunction

   function automatic bit inq(input logic [4:0] r);
      foreach (pend[k]) if (pend[k] == int'(r)) return 1;
      return 0;
   endfunction

   task automatic drop(input int r);
      for (int k = pend.size() - 1; k >= 0; k--) if (pend[k] == r) pend.delete(k);
   endtask

   task automatic model_reset();
      m_idv = 0; m_exv = 0;
      e = '{default: '0};
      pend.delete(); retire.delete();
   endtask

   // One clock: check combinational outputs, advance the model on the edge, check EX at negedge
   task automatic cyc();
      ref_t       d;
      logic [4:0] r1, r2, rd;
      bit         haz, iss;
      #1;
      d   = ref_dec(m_idi);
      r1  = m_idv ? m_idi[19:15] : 5'd0;
      r2  = m_idv ? m_idi[24:20] : 5'd0;
      rd  = m_idi[11:7];
      haz = (d.u1 && inq(r1)) || (d.u2 && inq(r2)) || (d.wr && inq(rd));
      iss = m_idv && !haz && (!m_exv || ex_ready) && !flush;
      m_acc = if_valid && (!m_idv || iss) && !flush;
      chk("if_ready", 32'(if_ready), 32'(flush || !m_idv || iss));
      chk("rs1", 32'(Rs1), 32'(r1));
      chk("rs2", 32'(Rs2), 32'(r2));
      if (ex_valid && ex_ready && !flush) seen.push_back(ex_imm);
      @(posedge clk);
      if (m_exv && ex_ready && !flush && e.wr && e.instr[11:7] != 0) retire.push_back(int'(e.instr[11:7]));
      if (wb_valid) drop(int'(wb_rd));
      if (flush && m_exv && e.wr) drop(int'(e.instr[11:7]));
      if (iss && d.wr && rd != 0) pend.push_back(int'(rd));
      if (flush) m_exv = 0;
      else if (iss) begin
         m_exv = 1; e.pc = m_idpc; e.r1 = regs[r1]; e.r2 = regs[r2];
         e.imm = d.imm; e.instr = m_idi; e.wr = d.wr; e.ill = d.ill;
      end else if (ex_ready) m_exv = 0;
      if (flush) m_idv = 0;
      else if (m_acc) begin m_idv = 1; m_idi = if_instr; m_idpc = if_pc; end
      else if (iss) m_idv = 0;
      @(negedge clk);
      if (wb_valid && wb_rd != 0) regs[wb_rd] = wb_data;
      chk("ex_valid", 32'(ex_valid), 32'(m_exv));
      if (m_exv) begin
         chk("ex_pc", ex_pc, e.pc);
         chk("ex_rs1_val", ex_rs1_val, e.r1);
         chk("ex_rs2_val", ex_rs2_val, e.r2);
         chk("ex_imm", ex_imm, e.imm);
         chk("ex_rd", 32'(ex_rd), 32'(e.instr[11:7]));
         chk("ex_regwrite", 32'(ex_regwrite), 32'(e.wr));
         chk("ex_illegal", 32'(ex_illegal), 32'(e.ill));
         chk("ex_opcode", 32'(ex_opcode), 32'(e.instr[6:0]));
         chk("ex_funct3", 32'(ex_funct3), 32'(e.instr[14:12]));
         chk("ex_funct7b5", 32'(ex_funct7b5), 32'(e.instr[30]));
      end
   endtask

   task automatic feed(input logic [31:0] ins);
      if_valid = 1; if_instr = ins; if_pc = if_pc + 32'd4;
   endtask

   task automatic idle();
      if_valid = 0; flush = 0; wb_valid = 0;
   endtask

   task automatic set_wb(input int r, input logic [31:0] v);
      wb_valid = 1; wb_rd = 5'(r); wb_data = v;
      for (int k = retire.size() - 1; k >= 0; k--) if (retire[k] == r) retire.delete(k);
   endtask

   task automatic drain();
      idle(); ex_ready = 1;
      for (int k = 0; k < 60; k++) begin
         if (pend.size() == 0 && !m_idv && !m_exv) break;
         if (retire.size() > 0) set_wb(retire[0], $urandom);
         else wb_valid = 0;
         cyc();
      end
      wb_valid = 0;
      chk("drain_ex_valid", 32'(ex_valid), 0);
      chk("drain_if_ready", 32'(if_ready), 1);
   endtask

   function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {f7, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0]  op;
      case ($urandom_range(0, 9))
         0: op = 7'h37; 1: op = 7'h17; 2: op = 7'h6F; 3: op = 7'h67; 4: op = 7'h03;
         5: op = 7'h13; 6: op = 7'h33; 7: op = 7'h23; 8: op = 7'h63; default: op = 7'h0B;
      endcase
      w = $urandom;
      w[6:0]   = op;
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      return w;
   endfunction

   initial begin
      logic [12:0] bimm;
      logic [31:0] beq_w;
      for (int k = 0; k < 32; k++) regs[k] = (k == 0) ? 32'd0 : $urandom;
      reset = 0; if_pc = 32'h1000; if_instr = 0; ex_ready = 1; wb_rd = 0; wb_data = 0;
      idle();
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_ex_valid", 32'(ex_valid), 0);
      chk("rst_ex_imm", ex_imm, 0);
      chk("rst_ex_regwrite", 32'(ex_regwrite), 0);
      reset = 1;

      // back-to-back independent addi
      feed(enc_i(7'h13, 5, 0, 12'd7)); cyc();
      feed(enc_i(7'h13, 6, 0, 12'd3)); cyc();
      chk("b2b_first_imm", ex_imm, 32'd7);
      idle(); cyc();
      chk("b2b_second_valid", 32'(ex_valid), 1);
      chk("b2b_second_imm", ex_imm, 32'd3);
      drain();

      // RAW: sub waits for x5 writeback plus one cycle
      feed(enc_r(7'h00, 5, 1, 2)); cyc();
      feed(enc_r(7'h20, 7, 5, 2)); cyc();
      idle(); cyc();
      chk("raw_stall_if_ready", 32'(if_ready), 0);
      chk("raw_stall_ex_valid", 32'(ex_valid), 0);
      set_wb(5, 32'h1234_5678); cyc(); wb_valid = 0;
      chk("raw_same_cycle_wb", 32'(ex_valid), 0);
      cyc();
      chk("raw_issue_valid", 32'(ex_valid), 1);
      chk("raw_rs1_new", ex_rs1_val, 32'h1234_5678);
      chk("raw_rd", 32'(ex_rd), 7);
      drain();

      // backpressure: three packets, none lost or duplicated
      seen.delete();
      feed(enc_i(7'h13, 10, 0, 12'd1)); cyc();
      feed(enc_i(7'h13, 11, 0, 12'd2)); cyc();
      ex_ready = 0; feed(enc_i(7'h13, 12, 0, 12'd3));
      repeat (3) begin
         cyc();
         chk("bp_hold_imm", ex_imm, 32'd1);
         chk("bp_if_ready", 32'(if_ready), 0);
      end
      ex_ready = 1;
      for (int k = 0; k < 10; k++) begin cyc(); if (m_acc) break; end
      drain();
      chk("bp_count", seen.size(), 3);
      for (int k = 0; k < 3 && k < seen.size(); k++) chk("bp_order", seen[k], 32'(k + 1));

      // flush kills lw x9 in EX and add in ID
      feed(enc_i(7'h03, 9, 0, 12'd0)); cyc();
      feed(enc_r(7'h00, 4, 1, 2)); cyc();
      ex_ready = 0; feed(enc_i(7'h13, 13, 0, 12'd5)); flush = 1; cyc(); flush = 0;
      chk("flush_ex_valid", 32'(ex_valid), 0);
      chk("flush_if_ready", 32'(if_ready), 1);
      ex_ready = 1; feed(enc_r(7'h00, 8, 9, 9)); cyc();
      idle(); cyc();
      chk("flush_x9_free", 32'(ex_valid), 1);
      chk("flush_x9_rd", 32'(ex_rd), 8);
      drain();

      // immediates and x0
      bimm  = 13'h1FFC;
      beq_w = {bimm[12], bimm[10:5], 5'd2, 5'd1, 3'b000, bimm[4:1], bimm[11], 7'h63};
      feed(beq_w); cyc(); idle(); cyc();
      chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
      chk("beq_regwrite", 32'(ex_regwrite), 0);
      feed({20'hABCDE, 5'd3, 7'h37}); cyc(); idle(); cyc();
      chk("lui_imm", ex_imm, 32'hABCD_E000);
      drain();
      feed(enc_i(7'h13, 0, 0, 12'd1)); cyc();
      feed(enc_i(7'h13, 0, 0, 12'd2)); cyc();
      chk("x0_first_imm", ex_imm, 32'd1);
      idle(); cyc();
      chk("x0_no_stall", 32'(ex_valid), 1);
      chk("x0_second_imm", ex_imm, 32'd2);
      chk("x0_regwrite", 32'(ex_regwrite), 1);
      drain();

      // random traffic
      repeat (3000) begin
         if_valid = ($urandom % 4) != 0;
         if_instr = rand_instr();
         if_pc    = $urandom & 32'hFFFF_FFFC;
         ex_ready = ($urandom % 4) != 0;
         flush    = ($urandom % 40) == 0;
         if (retire.size() > 0 && ($urandom % 3) == 0) set_wb(retire[0], $urandom);
         else wb_valid = 0;
         cyc();
      end

      // mid-stream asynchronous reset
      if_valid = 1; if_instr = rand_instr(); ex_ready = 0;
      #2 reset = 0;
      #1;
      chk("async_rst_ex_valid", 32'(ex_valid), 0);
      chk("async_rst_ex_pc", ex_pc, 0);
      chk("async_rst_ex_imm", ex_imm, 0);
      chk("async_rst_rs1", 32'(Rs1), 0);
      model_reset();
      idle(); ex_ready = 1;
      @(posedge clk); @(negedge clk);
      reset = 1;
      #1;
      chk("post_rst_if_ready", 32'(if_ready), 1);
      @(negedge clk);
      feed(enc_r(7'h00, 5, 1, 2)); cyc();
      idle(); cyc();
      chk("post_rst_no_busy", 32'(ex_valid), 1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
